// File: rtl/quad_dec_pkg.sv
// Shared definitions for the Quad_Dec system-ID checker and its helpers.
//   state_e             : checker FSM states
//   SYSID_ADDR_*        : word addresses inside the sysid slave
//   SYSID_EXPECTED_TS_DEFAULT : build timestamp of the matching software build
package quad_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_ID  = 2'd1,
    RD_TS  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_TS_DEFAULT = 32'h5AF0_5BBB;

endpackage

// File: rtl/quad_dec_stall_timer.sv
// 16-bit stall counter for Avalon masters.
//   clock, reset : clock, synchronous active-high reset
//   clear        : zero the count (wins over enable)
//   enable       : count one stalled cycle
//   limit        : count value at which expired asserts
//   count        : current count
//   expired      : count == limit
module quad_dec_stall_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic [15:0] count,
  output logic        expired
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable && (count_q != 16'hFFFF)) // saturate instead of wrapping
      count_d = count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign expired = (count_q == limit);

endmodule

// File: rtl/quad_dec_sysid_checker.sv
// Avalon-MM read master that reads the sysid slave (word 0 = ID, word 1 =
// build timestamp), compares against expected constants and reports.
//   clock, reset          : clock, synchronous active-high reset
//   start                 : one-cycle request, honoured only in IDLE
//   avm_address/avm_read  : read request to the sysid slave
//   avm_waitrequest       : slave stall
//   avm_readdata          : slave data, valid when read && !waitrequest
//   busy, done            : check in progress / one-cycle result strobe
//   pass, id_ok, ts_ok    : comparison results
//   timeout               : a read was abandoned after TIMEOUT_CYCLES stalls
//   id_value, ts_value    : last captured words
module quad_dec_sysid_checker
  import quad_dec_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS_DEFAULT,
  parameter bit          CHECK_TS       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        avm_read_q, avm_read_d, avm_address_q, avm_address_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic        id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  // Which words were actually read in this run; unread words compare as 0.
  logic        id_rd_q, id_rd_d, ts_rd_q, ts_rd_d;

  logic        tmr_expired;
  logic [15:0] tmr_count;
  logic        in_rd;

  assign in_rd = (state_q == RD_ID) || (state_q == RD_TS);

  // Cleared on every state change, so each RD state starts from zero.
  quad_dec_stall_timer u_stall_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_d != state_q),
    .enable  (in_rd && avm_waitrequest),
    .limit   (TMO_LIMIT),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_rd_d    = id_rd_q;
    ts_rd_d    = ts_rd_q;

    case (state_q)
      IDLE: if (start) begin
        state_d   = RD_ID;
        pass_d    = 1'b0;
        id_ok_d   = 1'b0;
        ts_ok_d   = 1'b0;
        timeout_d = 1'b0;
        id_rd_d   = 1'b0;
        ts_rd_d   = 1'b0;
      end
      // Completion is tested first so a transfer in the expiry cycle succeeds.
      RD_ID: if (!avm_waitrequest) begin
        id_value_d = avm_readdata;
        id_rd_d    = 1'b1;
        state_d    = CHECK_TS ? RD_TS : REPORT;
      end else if (tmr_expired) begin
        timeout_d = 1'b1;
        state_d   = REPORT;
      end
      RD_TS: if (!avm_waitrequest) begin
        ts_value_d = avm_readdata;
        ts_rd_d    = 1'b1;
        state_d    = REPORT;
      end else if (tmr_expired) begin
        timeout_d = 1'b1;
        state_d   = REPORT;
      end
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Results are registered on entry to REPORT so they line up with done.
    if ((state_d == REPORT) && (state_q != REPORT)) begin
      done_d  = 1'b1;
      id_ok_d = id_rd_d && (id_value_d == EXPECTED_ID);
      ts_ok_d = CHECK_TS ? (ts_rd_d && (ts_value_d == EXPECTED_TS)) : 1'b1;
      pass_d  = id_ok_d && ts_ok_d && !timeout_d;
    end

    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = (state_d == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      id_rd_q       <= 1'b0;
      ts_rd_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      id_value_q    <= id_value_d;
      ts_value_q    <= ts_value_d;
      id_rd_q       <= id_rd_d;
      ts_rd_q       <= ts_rd_d;
    end
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
